// File: rtl/mxint_dequant_serializer_if.sv
// Stream interface for mxint_dequant_serializer.
//   Input side : one MxInt block per valid/ready handshake (mantissas + shared exponent).
//   Output side: PAR fixed-point elements per beat, with last on the final beat of a block.
// Modports:
//   master - block producer / beat consumer (drives block, data_in_valid, data_out_ready).
//   slave  - the serializer (drives data_in_ready and the beat outputs).
interface mxint_dequant_serializer_if #(
    parameter int unsigned IN_MAN_WIDTH = 8,
    parameter int unsigned IN_EXP_WIDTH = 4,
    parameter int unsigned OUT_WIDTH    = 12,
    parameter int unsigned BLOCK_SIZE   = 4,
    parameter int unsigned PAR          = 2
) ();
    logic [BLOCK_SIZE-1:0][IN_MAN_WIDTH-1:0] mdata_in;
    logic [IN_EXP_WIDTH-1:0]                 edata_in;
    logic                                    data_in_valid;
    logic                                    data_in_ready;
    logic [PAR-1:0][OUT_WIDTH-1:0]           data_out;
    logic                                    data_out_valid;
    logic                                    data_out_last;
    logic                                    data_out_ready;

    modport master (
        output mdata_in, edata_in, data_in_valid, data_out_ready,
        input  data_in_ready, data_out, data_out_valid, data_out_last
    );

    modport slave (
        input  mdata_in, edata_in, data_in_valid, data_out_ready,
        output data_in_ready, data_out, data_out_valid, data_out_last
    );
endinterface

// File: rtl/mxint_dequant_serializer.sv
// MxInt block dequantizer and serializer.
// Captures one block (BLOCK_SIZE signed mantissas + shared signed exponent) on accept and
// emits it as BLOCK_SIZE/PAR beats of PAR signed fixed-point elements, value M * 2^s with
// s = E + OUT_FRAC_WIDTH - (IN_MAN_WIDTH-1). Right shifts floor (arithmetic).
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-low reset
//   bus - mxint_dequant_serializer_if.slave (block input handshake, beat output handshake)
// Build option:
//   MXINT_DEQUANT_SAT_EN - saturate each result to the OUT_WIDTH signed range; otherwise wrap.
module mxint_dequant_serializer #(
    parameter int unsigned IN_MAN_WIDTH   = 8,
    parameter int unsigned IN_EXP_WIDTH   = 4,
    parameter int unsigned OUT_WIDTH      = 12,
    parameter int unsigned OUT_FRAC_WIDTH = 6,
    parameter int unsigned BLOCK_SIZE     = 4,
    parameter int unsigned PAR            = 2
) (
    input logic                       clk,
    input logic                       rst,
    mxint_dequant_serializer_if.slave bus
);
    localparam int unsigned NumBeats = BLOCK_SIZE / PAR;
    localparam int unsigned BeatW    = (NumBeats > 1) ? $clog2(NumBeats) : 1;
    // Full-precision intermediate: no bits lost before the final narrowing.
    localparam int unsigned FullW    = IN_MAN_WIDTH + (2 ** (IN_EXP_WIDTH - 1)) + OUT_FRAC_WIDTH;
    localparam int unsigned ClogA    = $clog2(OUT_FRAC_WIDTH + 1);
    localparam int unsigned ClogB    = $clog2(IN_MAN_WIDTH);
    localparam int unsigned ClogMax  = (ClogA > ClogB) ? ClogA : ClogB;
    localparam int unsigned ShW      = ((IN_EXP_WIDTH > ClogMax) ? IN_EXP_WIDTH : ClogMax) + 2;

    localparam logic [BeatW-1:0] LastBeat = BeatW'(NumBeats - 1);
    localparam logic [ShW-1:0]   ShOff    = ShW'(OUT_FRAC_WIDTH) - ShW'(IN_MAN_WIDTH - 1);

    if (BLOCK_SIZE % PAR != 0) begin : g_par_check
        $error("BLOCK_SIZE must be a multiple of PAR");
    end
    if (FullW <= OUT_WIDTH) begin : g_width_check
        $error("intermediate must be wider than OUT_WIDTH");
    end

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e                                  state_q, state_d;
    logic [BeatW-1:0]                        b_q, b_d;
    logic [BLOCK_SIZE-1:0][IN_MAN_WIDTH-1:0] man_q, man_d;
    logic [IN_EXP_WIDTH-1:0]                 exp_q, exp_d;

    logic b_last;
    logic in_ready;
    logic accept;

    assign b_last = (b_q == LastBeat);
    assign accept = bus.data_in_valid && in_ready;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            b_q     <= '0;
            man_q   <= '0;
            exp_q   <= '0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            man_q   <= man_d;
            exp_q   <= exp_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        man_d   = man_q;
        exp_d   = exp_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StBusy;
                    b_d     = '0;
                    man_d   = bus.mdata_in;
                    exp_d   = bus.edata_in;
                end
            end
            StBusy: begin
                if (bus.data_out_ready) begin
                    if (!b_last) begin
                        b_d = b_q + 1'b1;
                    end else if (accept) begin
                        // Next block follows the last beat with no bubble.
                        b_d   = '0;
                        man_d = bus.mdata_in;
                        exp_d = bus.edata_in;
                    end else begin
                        state_d = StIdle;
                        b_d     = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs
    always_comb begin
        in_ready           = (state_q == StIdle) || (b_last && bus.data_out_ready);
        bus.data_in_ready  = in_ready;
        bus.data_out_valid = (state_q == StBusy);
        bus.data_out_last  = (state_q == StBusy) && b_last;
    end

    // Datapath: shift amount is common to the block, one mux and shift per lane.
    logic [ShW-1:0]    shift;
    logic              shift_neg;
    logic [ShW-1:0]    shift_mag;
    logic [PAR-1:0][IN_MAN_WIDTH-1:0] lane_man;
    logic signed [FullW-1:0] ext  [PAR];
    logic signed [FullW-1:0] full [PAR];

    assign shift     = {{(ShW - IN_EXP_WIDTH){exp_q[IN_EXP_WIDTH-1]}}, exp_q} + ShOff;
    assign shift_neg = shift[ShW-1];
    assign shift_mag = shift_neg ? (~shift + 1'b1) : shift;

    always_comb begin
        lane_man = '0;
        for (int k = 0; k < int'(PAR); k++) begin
            for (int j = 0; j < int'(BLOCK_SIZE); j++) begin
                if (j == int'(b_q) * int'(PAR) + k) lane_man[k] = man_q[j];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < int'(PAR); k++) begin
            ext[k]  = {{(FullW - IN_MAN_WIDTH){lane_man[k][IN_MAN_WIDTH-1]}}, lane_man[k]};
            full[k] = shift_neg ? (ext[k] >>> shift_mag) : (ext[k] <<< shift_mag);
        end
    end

`ifdef MXINT_DEQUANT_SAT_EN
    localparam logic signed [FullW-1:0] OutMax = FullW'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [FullW-1:0] OutMin = ~OutMax;

    always_comb begin
        for (int k = 0; k < int'(PAR); k++) begin
            if (full[k] > OutMax) begin
                bus.data_out[k] = OutMax[OUT_WIDTH-1:0];
            end else if (full[k] < OutMin) begin
                bus.data_out[k] = OutMin[OUT_WIDTH-1:0];
            end else begin
                bus.data_out[k] = full[k][OUT_WIDTH-1:0];
            end
        end
    end
`else
    // Wrap: upper bits of the intermediate are intentionally dropped.
    logic unused_full_hi;

    always_comb begin
        unused_full_hi = 1'b0;
        for (int k = 0; k < int'(PAR); k++) begin
            bus.data_out[k] = full[k][OUT_WIDTH-1:0];
            unused_full_hi  = unused_full_hi ^ (^full[k][FullW-1:OUT_WIDTH]);
        end
    end
`endif
endmodule
